// File: rtl/udp_tx_arbiter.sv
// rtl/udp_tx_arbiter.sv - round-robin arbiter sharing the UDP transmitter between two packet channels
module udp_tx_arbiter #(
    parameter int IPG_CYCLES     = 12,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ch0_req,
    input  logic [15:0] ch0_byte_num,
    input  logic [31:0] ch0_data,
    output logic        ch0_rd_en,
    output logic        ch0_grant,
    output logic        ch0_done,
    input  logic        ch1_req,
    input  logic [15:0] ch1_byte_num,
    input  logic [31:0] ch1_data,
    output logic        ch1_rd_en,
    output logic        ch1_grant,
    output logic        ch1_done,
    input  logic        arp_busy,
    output logic        udp_tx_start_en,
    output logic [15:0] udp_tx_byte_num,
    input  logic        udp_tx_req,
    output logic [31:0] udp_tx_data,
    input  logic        udp_tx_done,
    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE, START, SEND, GAP} state_t;

    localparam logic [7:0]  GAP_LAST = 8'(IPG_CYCLES - 1);
    localparam logic [19:0] WD_LAST  = 20'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic        last;
    logic [7:0]  gap_cnt;
    logic [19:0] wd_cnt;
    logic        pick1;
    logic [15:0] pick_bn;

    // On a tie the channel not served last wins; otherwise the lone requester.
    always_comb begin
        pick1   = (ch0_req & ch1_req) ? ~last : ch1_req;
        pick_bn = pick1 ? ch1_byte_num : ch0_byte_num;
    end

    assign ch0_rd_en   = (state == SEND) & udp_tx_req & ch0_grant;
    assign ch1_rd_en   = (state == SEND) & udp_tx_req & ch1_grant;
    assign udp_tx_data = ch0_grant ? ch0_data : (ch1_grant ? ch1_data : 32'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            last            <= 1'b1;
            gap_cnt         <= 8'd0;
            wd_cnt          <= 20'd0;
            ch0_grant       <= 1'b0;
            ch1_grant       <= 1'b0;
            ch0_done        <= 1'b0;
            ch1_done        <= 1'b0;
            udp_tx_start_en <= 1'b0;
            udp_tx_byte_num <= 16'd0;
            timeout_err     <= 1'b0;
        end else begin
            ch0_done        <= 1'b0;
            ch1_done        <= 1'b0;
            timeout_err     <= 1'b0;
            udp_tx_start_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (!arp_busy && (ch0_req || ch1_req)) begin
                        last            <= pick1;
                        ch0_grant       <= ~pick1;
                        ch1_grant       <= pick1;
                        udp_tx_byte_num <= pick_bn;
                        if (pick_bn != 16'd0) begin
                            udp_tx_start_en <= 1'b1;
                            state           <= START;
                        end else begin
                            // Empty packet: complete immediately without involving udp.
                            ch0_done <= ~pick1;
                            ch1_done <= pick1;
                            gap_cnt  <= 8'd0;
                            state    <= GAP;
                        end
                    end
                end
                START: begin
                    wd_cnt <= 20'd0;
                    state  <= SEND;
                end
                SEND: begin
                    if (udp_tx_done) begin
                        ch0_done  <= ch0_grant;
                        ch1_done  <= ch1_grant;
                        ch0_grant <= 1'b0;
                        ch1_grant <= 1'b0;
                        gap_cnt   <= 8'd0;
                        state     <= GAP;
                    end else if (wd_cnt == WD_LAST) begin
                        ch0_grant   <= 1'b0;
                        ch1_grant   <= 1'b0;
                        timeout_err <= 1'b1;
                        gap_cnt     <= 8'd0;
                        state       <= GAP;
                    end else begin
                        wd_cnt <= wd_cnt + 20'd1;
                    end
                end
                GAP: begin
                    ch0_grant <= 1'b0;
                    ch1_grant <= 1'b0;
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// tb/tb_udp_tx_arbiter.sv - self-checking bench for udp_tx_arbiter with a udp responder model
module tb_udp_tx_arbiter;

    localparam int IPG = 12;
    localparam int TMO = 100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ch0_req, ch1_req;
    logic [15:0] ch0_byte_num, ch1_byte_num;
    logic [31:0] ch0_data, ch1_data;
    logic        ch0_rd_en, ch1_rd_en, ch0_grant, ch1_grant, ch0_done, ch1_done;
    logic        arp_busy;
    logic        udp_tx_start_en;
    logic [15:0] udp_tx_byte_num;
    logic        udp_tx_req;
    logic [31:0] udp_tx_data;
    logic        udp_tx_done;
    logic        timeout_err;

    udp_tx_arbiter #(.IPG_CYCLES(IPG), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .ch0_req(ch0_req), .ch0_byte_num(ch0_byte_num), .ch0_data(ch0_data),
        .ch0_rd_en(ch0_rd_en), .ch0_grant(ch0_grant), .ch0_done(ch0_done),
        .ch1_req(ch1_req), .ch1_byte_num(ch1_byte_num), .ch1_data(ch1_data),
        .ch1_rd_en(ch1_rd_en), .ch1_grant(ch1_grant), .ch1_done(ch1_done),
        .arp_busy(arp_busy), .udp_tx_start_en(udp_tx_start_en),
        .udp_tx_byte_num(udp_tx_byte_num), .udp_tx_req(udp_tx_req),
        .udp_tx_data(udp_tx_data), .udp_tx_done(udp_tx_done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int n_start = 0, n_done = 0, n_to = 0;
    int rd0_cnt = 0, rd1_cnt = 0, grant_cyc = 0, overlap = 0, mon_err = 0;
    int start_cyc[$], start_ch[$], start_bn[$];
    int done_cyc[$], done_ch[$];
    int to_cyc[$], to_grant[$];
    bit done_en = 1'b1;
    bit model_last;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        ch0_data = 32'd0;
        ch1_data = 32'd0;
        forever begin
            @(posedge clk); #1;
            ch0_data = $urandom;
            ch1_data = $urandom;
        end
    end

    // udp responder: one word request per 4 bytes, done two cycles after the last request
    initial begin
        int words;
        udp_tx_req  = 1'b0;
        udp_tx_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (udp_tx_start_en === 1'b1) begin
                words = (int'(udp_tx_byte_num) + 3) / 4;
                @(posedge clk); #1;
                for (int i = 0; i < words; i++) begin
                    udp_tx_req = 1'b1;
                    @(posedge clk); #1;
                end
                udp_tx_req = 1'b0;
                if (done_en) begin
                    @(posedge clk); #1;
                    udp_tx_done = 1'b1;
                    @(posedge clk); #1;
                    udp_tx_done = 1'b0;
                end
            end
        end
    end

    initial begin
        bit prev_start = 1'b0;
        logic [31:0] exp_data;
        forever begin
            @(negedge clk);
            if (udp_tx_start_en === 1'b1) begin
                start_cyc.push_back(cyc);
                start_ch.push_back(ch1_grant ? 1 : (ch0_grant ? 0 : 2));
                start_bn.push_back(int'(udp_tx_byte_num));
                n_start++;
                if (prev_start) mon_err++;
            end
            prev_start = (udp_tx_start_en === 1'b1);
            if (ch0_done === 1'b1 || ch1_done === 1'b1) begin
                done_cyc.push_back(cyc);
                done_ch.push_back(ch1_done ? 1 : 0);
                n_done++;
                if (ch0_done && ch1_done) mon_err++;
            end
            if (timeout_err === 1'b1) begin
                to_cyc.push_back(cyc);
                to_grant.push_back(int'(ch0_grant | ch1_grant));
                n_to++;
            end
            if (ch0_rd_en === 1'b1) rd0_cnt++;
            if (ch1_rd_en === 1'b1) rd1_cnt++;
            if (ch0_grant === 1'b1 || ch1_grant === 1'b1) grant_cyc++;
            if (ch0_grant === 1'b1 && ch1_grant === 1'b1) overlap++;
            if (ch0_rd_en === 1'b1 && !(ch0_grant && udp_tx_req)) mon_err++;
            if (ch1_rd_en === 1'b1 && !(ch1_grant && udp_tx_req)) mon_err++;
            exp_data = ch0_grant ? ch0_data : (ch1_grant ? ch1_data : 32'd0);
            if (udp_tx_data !== exp_data) mon_err++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_ev(input int which, input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i <= budget; i++) begin
            if ((which == 0 && n_start >= target) || (which == 1 && n_done >= target) ||
                (which == 2 && n_to >= target)) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_grant0"}, ch0_grant, 1'b0);
        check({tag, "_grant1"}, ch1_grant, 1'b0);
        check({tag, "_done"}, {ch0_done, ch1_done}, 2'b00);
        check({tag, "_start"}, udp_tx_start_en, 1'b0);
        check({tag, "_bn"}, udp_tx_byte_num, 16'd0);
        check({tag, "_to"}, timeout_err, 1'b0);
        check({tag, "_rd"}, {ch0_rd_en, ch1_rd_en}, 2'b00);
        check({tag, "_data"}, udp_tx_data, 32'd0);
    endtask

    // One packet: model picks the winner, checks start, byte count, word reads and completion.
    task automatic run_pkt(input bit r0, input bit r1, input int b0, input int b1,
                           input string tag, input int ref_cyc);
        int s0, d0, rd0a, rd1a, win, bn;
        bit ok;
        s0   = n_start;
        d0   = n_done;
        rd0a = rd0_cnt;
        rd1a = rd1_cnt;
        win  = (r0 && r1) ? int'(!model_last) : int'(r1);
        bn   = win ? b1 : b0;
        ch0_byte_num = 16'(b0);
        ch1_byte_num = 16'(b1);
        ch0_req = r0;
        ch1_req = r1;
        wait_ev(0, s0 + 1, 200, ok);
        ch0_req = 1'b0;
        ch1_req = 1'b0;
        check({tag, "_start_seen"}, ok, 1'b1);
        if (ok) begin
            check({tag, "_start_ch"}, start_ch[s0], win);
            check({tag, "_start_bn"}, start_bn[s0], bn);
            if (ref_cyc >= 0) check({tag, "_gap"}, start_cyc[s0] - ref_cyc, IPG + 1);
        end
        wait_ev(1, d0 + 1, 300, ok);
        check({tag, "_done_seen"}, ok, 1'b1);
        if (ok) check({tag, "_done_ch"}, done_ch[d0], win);
        check({tag, "_rd_win"}, win ? rd1_cnt - rd1a : rd0_cnt - rd0a, (bn + 3) / 4);
        check({tag, "_rd_other"}, win ? rd0_cnt - rd0a : rd1_cnt - rd1a, 0);
        model_last = win[0];
    endtask

    initial begin
        bit ok;
        int s0, d0, t0, g0, ov0, k, b0, b1, win, pat;

        rst_n = 1'b0;
        ch0_req = 1'b0;
        ch1_req = 1'b0;
        ch0_byte_num = 16'd0;
        ch1_byte_num = 16'd0;
        arp_busy = 1'b0;
        step(3);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        model_last = 1'b1;
        step(2);

        // continuous tie: strict alternation starting from channel 0
        s0 = n_start;
        d0 = n_done;
        ov0 = overlap;
        ch0_byte_num = 16'd32;
        ch1_byte_num = 16'd48;
        ch0_req = 1'b1;
        ch1_req = 1'b1;
        wait_ev(0, s0 + 4, 2000, ok);
        ch0_req = 1'b0;
        ch1_req = 1'b0;
        check("rr_starts_seen", ok, 1'b1);
        wait_ev(1, d0 + 4, 500, ok);
        check("rr_dones_seen", ok, 1'b1);
        if (n_start >= s0 + 4) begin
            for (int i = 0; i < 4; i++) begin
                win = int'(!model_last);
                check($sformatf("rr_ch_%0d", i), start_ch[s0 + i], win);
                check($sformatf("rr_bn_%0d", i), start_bn[s0 + i], win ? 48 : 32);
                model_last = win[0];
            end
        end
        check("rr_no_overlap", overlap - ov0, 0);

        run_pkt(1'b1, 1'b0, 64, 0, "ch0_64", done_cyc[n_done - 1]);
        run_pkt(1'b1, 1'b0, 64, 0, "ch0_64_next", done_cyc[n_done - 1]);

        for (int it = 0; it < 8; it++) begin
            pat = int'($urandom_range(2, 0));
            b0  = int'($urandom_range(255, 1));
            b1  = int'($urandom_range(255, 1));
            run_pkt(pat != 1, pat != 0, b0, b1, $sformatf("rnd%0d", it), done_cyc[n_done - 1]);
        end

        // ARP holds off a pending request until it clears
        s0 = n_start;
        g0 = grant_cyc;
        arp_busy = 1'b1;
        ch1_byte_num = 16'($urandom_range(255, 1));
        ch1_req = 1'b1;
        step(50);
        check("arp_no_start", n_start - s0, 0);
        check("arp_no_grant", grant_cyc - g0, 0);
        arp_busy = 1'b0;
        k = cyc;
        wait_ev(0, s0 + 1, 20, ok);
        ch1_req = 1'b0;
        check("arp_start_seen", ok, 1'b1);
        if (ok) begin
            check("arp_latency", start_cyc[s0] - k, 1);
            check("arp_ch", start_ch[s0], 1);
        end
        d0 = n_done;
        wait_ev(1, d0 + 1, 300, ok);
        check("arp_done_seen", ok, 1'b1);
        model_last = 1'b1;

        // watchdog: udp never reports done
        done_en = 1'b0;
        s0 = n_start;
        d0 = n_done;
        t0 = n_to;
        ch0_byte_num = 16'd64;
        ch0_req = 1'b1;
        wait_ev(0, s0 + 1, 200, ok);
        ch0_req = 1'b0;
        check("to_start_seen", ok, 1'b1);
        wait_ev(2, t0 + 1, 400, ok);
        check("to_seen", ok, 1'b1);
        if (ok && n_start > s0) begin
            check("to_latency", to_cyc[t0] - start_cyc[s0], TMO + 1);
            check("to_grant_dropped", to_grant[t0], 0);
        end
        step(2);
        check("to_no_done", n_done - d0, 0);
        check("to_single_pulse", n_to - t0, 1);
        model_last = 1'b0;
        done_en = 1'b1;
        run_pkt(1'b0, 1'b1, 0, int'($urandom_range(255, 1)), "after_to",
                (n_to > t0) ? to_cyc[t0] : -1);

        // zero-byte packet completes without a start pulse
        step(IPG + 2);
        s0 = n_start;
        d0 = n_done;
        ch1_byte_num = 16'd0;
        ch1_req = 1'b1;
        k = cyc;
        wait_ev(1, d0 + 1, 50, ok);
        ch1_req = 1'b0;
        check("zero_done_seen", ok, 1'b1);
        if (ok) begin
            check("zero_done_ch", done_ch[d0], 1);
            check("zero_latency", done_cyc[d0] - k, 1);
        end
        check("zero_no_start", n_start - s0, 0);
        model_last = 1'b1;
        run_pkt(1'b1, 1'b0, int'($urandom_range(255, 1)), 0, "after_zero",
                (n_done > d0) ? done_cyc[d0] : -1);

        // reset in the middle of SEND
        s0 = n_start;
        ch0_byte_num = 16'd64;
        ch0_req = 1'b1;
        wait_ev(0, s0 + 1, 200, ok);
        ch0_req = 1'b0;
        check("rst_start_seen", ok, 1'b1);
        step(6);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        check_idle_outputs("midsend_rst");
        model_last = 1'b1;
        step(25);
        run_pkt(1'b1, 1'b1, int'($urandom_range(255, 1)), int'($urandom_range(255, 1)),
                "post_rst_tie", -1);

        check("monitor_errors", mon_err, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
